morph_pass_sequencer: RTL and testbench
=======================================

MORPH_PASS_SEQUENCER -- requirements
Module: morph_pass_sequencer

Interface
REQ-001 Parameter: IMG_W, default 640, frame width in pixels.
REQ-002 Parameter: IMG_H, default 480, frame height in lines.
REQ-003 Parameter: ADDR_W, default 19, pixel address width.
REQ-004 Parameter: PIPE_LAT, default 3, cycles from rd_addr issue to filtered pixel at RAM input.
REQ-005 Port: vga_ctrl_clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-006 Port: pll_lock  in  1  PLL locked.
REQ-007 Port: start  in  1  run request; sampled only in IDLE.
REQ-008 Port: num_passes  in  3  passes to run (0 = plain copy, 1..4; values above 4 clamp to 4).
REQ-009 Port: op_seq  in  4  per-pass op; bit i = pass i, 0 = erosion, 1 = dilation.
REQ-010 Port: rd_addr  out  ADDR_W  source pixel address; rd_src  out  2  source (00 ROM, 01 RAM A, 10 RAM B).
REQ-011 Port: wr_addr  out  ADDR_W  destination address; wr_en  out  1  write strobe; wr_dst  out  1  destination (0 = A, 1 = B).
REQ-012 Port: erosion_en, dilation_en  out  1 each  filter enables, never both high.
REQ-013 Port: busy  out  1; done  out  1  one-cycle completion pulse; abort  out  1  sticky lock-loss flag.
REQ-014 Port: vga_flag  out  1  display enable; disp_buf  out  1  buffer shown (0 = A, 1 = B).

Function
REQ-015 States: WAIT_LOCK, IDLE, SETUP, STREAM, DRAIN, NEXT; WAIT_LOCK -> IDLE when pll_lock high.
REQ-016 IDLE + start -> SETUP: latch num_passes (clamped) and op_seq; pass index p = 0; busy high from the next cycle.
REQ-017 Pass 0 reads ROM (rd_src 00), writes A; pass p>0 reads the buffer written by pass p-1 and writes the other.
REQ-018 SETUP lasts 1 cycle: rd_addr = 0; enables set from op_seq[p] (both low when num_passes = 0).
REQ-019 STREAM: rd_addr increments by 1 per cycle from 0 to IMG_W*IMG_H-1 (307199 at default), then -> DRAIN.
REQ-020 wr_addr/wr_en are rd_addr/stream-valid delayed exactly PIPE_LAT cycles; IMG_W*IMG_H writes per pass, no gaps, no duplicates.
REQ-021 DRAIN: hold for PIPE_LAT cycles until the last write retires; filter enables stay valid until then.
REQ-022 NEXT: p+1 < passes -> SETUP with p+1; else assert done 1 cycle, disp_buf = last wr_dst, -> IDLE.
REQ-023 num_passes = 0 runs exactly one copy pass, ROM -> A.
REQ-024 vga_flag low while busy; high in IDLE once one run has completed since reset.
REQ-025 start while busy is ignored, not queued.
REQ-026 pll_lock low in any state other than WAIT_LOCK: next cycle wr_en low, enables low, busy low, abort set, no done, -> WAIT_LOCK; abort clears on the next accepted start.
REQ-027 Address counters never exceed IMG_W*IMG_H-1; no wrap within a pass.

Reset
REQ-028 rst high: state WAIT_LOCK, all addresses 0, rd_src 00, wr_dst 0, all strobes/enables/busy/done/abort/vga_flag 0, disp_buf 0.
REQ-029 rst mid-pass terminates immediately; no partial-pass completion or done after release.

Structure
REQ-030 Shared package morph_seq_pkg holds the state encoding, op codes (OP_ERO, OP_DIL), source codes (SRC_ROM, SRC_A, SRC_B), MAX_PASSES = 4.
REQ-031 One sub-module, frame_addr_gen: clear/enable pixel counter with last-pixel flag, instantiated for the read side; write side is the delay line.

Verification (IMG_W=8, IMG_H=4, PIPE_LAT=3)
REQ-032 pll_lock=1, start, num_passes=1, op_seq=0000 -> erosion_en high, rd_addr 0..31 from ROM, wr_addr 0..31 to A starting 3 cycles later, done once, disp_buf=0, vga_flag=1.
REQ-033 num_passes=2, op_seq=0010 -> pass0 erosion ROM->A, pass1 dilation A->B, 64 writes total, disp_buf=1.
REQ-034 num_passes=7, op_seq=1111 -> clamps to 4 dilation passes: ROM->A, A->B, B->A, A->B; done once.
REQ-035 pll_lock dropped at rd_addr=10 of pass 1 -> wr_en low next cycle, abort=1, no done; relock + start -> abort=0, full run completes.
REQ-036 start pulsed mid-STREAM and rst pulsed at rd_addr=20 -> start ignored; rst returns all outputs to reset values, no done after release.

Source files
------------

// File: rtl/morph_seq_pkg.sv
// Shared encodings for the morphology pass sequencer: FSM states, filter ops,
// read-source codes and the pass-count clamp.
package morph_seq_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_IDLE      = 3'd1,
    ST_SETUP     = 3'd2,
    ST_STREAM    = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_NEXT      = 3'd5
  } state_e;

  localparam logic OP_ERO = 1'b0;
  localparam logic OP_DIL = 1'b1;

  localparam logic [1:0] SRC_ROM = 2'b00;
  localparam logic [1:0] SRC_A   = 2'b01;
  localparam logic [1:0] SRC_B   = 2'b10;

  localparam int MAX_PASSES = 4;

  // A request for zero passes still runs one unfiltered copy pass.
  function automatic logic [2:0] clamp_passes(input logic [2:0] n);
    if (n == 3'd0) return 3'd1;
    if (n > 3'(MAX_PASSES)) return 3'(MAX_PASSES);
    return n;
  endfunction

  // Pass 0 reads the ROM; later passes read the buffer the previous pass wrote.
  function automatic logic [1:0] pass_src(input logic [1:0] p);
    if (p == 2'd0) return SRC_ROM;
    return p[0] ? SRC_A : SRC_B;
  endfunction

endpackage

// File: rtl/frame_addr_gen.sv
// Frame pixel counter: synchronous clear, count enable, saturates at the last
// pixel and flags it.
module frame_addr_gen #(
  parameter int N_PIX  = 307200,
  parameter int ADDR_W = 19
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              en_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;

  assign last_o = (addr_q == ADDR_W'(N_PIX - 1));
  assign addr_o = addr_q;

  always_comb begin
    addr_d = addr_q;
    if (clear_i) begin
      addr_d = '0;
    end else if (en_i && !last_o) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/morph_pass_sequencer.sv
// Sequences up to four erosion/dilation passes over a frame, ping-ponging
// between RAM A and RAM B, and hands the final buffer to the display.
module morph_pass_sequencer
  import morph_seq_pkg::*;
#(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int ADDR_W   = 19,
  parameter int PIPE_LAT = 3
) (
  input  logic              vga_ctrl_clk,
  input  logic              rst,
  input  logic              pll_lock,
  input  logic              start,
  input  logic [2:0]        num_passes,
  input  logic [3:0]        op_seq,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [1:0]        rd_src,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic              wr_dst,
  output logic              erosion_en,
  output logic              dilation_en,
  output logic              busy,
  output logic              done,
  output logic              abort,
  output logic              vga_flag,
  output logic              disp_buf,
  output logic [2:0]        dbg_state
);

  localparam int N_PIX = IMG_W * IMG_H;

  state_e      state_q, state_d;
  logic [2:0]  passes_q, passes_d;
  logic        copy_q, copy_d;
  logic [3:0]  ops_q, ops_d;
  logic [1:0]  pass_q, pass_d;
  logic [7:0]  drain_q, drain_d;
  logic        done_q, done_d;
  logic        abort_q, abort_d;
  logic        ran_q, ran_d;
  logic        disp_q, disp_d;

  logic              rd_last;
  logic              stream_v;
  logic              more_passes;
  logic              filt_on;
  logic [ADDR_W-1:0] rd_cnt;

  logic [PIPE_LAT-1:0] wv_q;
  logic [ADDR_W-1:0]   wa_q [PIPE_LAT];

  frame_addr_gen #(
    .N_PIX  (N_PIX),
    .ADDR_W (ADDR_W)
  ) u_rd_gen (
    .clk_i   (vga_ctrl_clk),
    .rst_i   (rst),
    .clear_i (state_q inside {ST_WAIT_LOCK, ST_IDLE, ST_NEXT}),
    .en_i    (state_q == ST_STREAM),
    .addr_o  (rd_cnt),
    .last_o  (rd_last)
  );

  assign stream_v    = (state_q == ST_STREAM);
  assign more_passes = (({1'b0, pass_q} + 3'd1) < passes_q);

  always_comb begin
    state_d  = state_q;
    passes_d = passes_q;
    copy_d   = copy_q;
    ops_d    = ops_q;
    pass_d   = pass_q;
    drain_d  = drain_q;
    done_d   = 1'b0;
    abort_d  = abort_q;
    ran_d    = ran_q;
    disp_d   = disp_q;
    // Lock loss overrides every other transition, including in IDLE.
    if (state_q != ST_WAIT_LOCK && !pll_lock) begin
      state_d = ST_WAIT_LOCK;
      abort_d = 1'b1;
      pass_d  = 2'd0;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: if (pll_lock) state_d = ST_IDLE;
        ST_IDLE: begin
          if (start) begin
            state_d  = ST_SETUP;
            passes_d = clamp_passes(num_passes);
            copy_d   = (num_passes == 3'd0);
            ops_d    = op_seq;
            pass_d   = 2'd0;
            abort_d  = 1'b0;
          end
        end
        ST_SETUP: state_d = ST_STREAM;
        ST_STREAM: begin
          drain_d = 8'd0;
          if (rd_last) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (drain_q == 8'(PIPE_LAT - 1)) state_d = ST_NEXT;
          else drain_d = drain_q + 8'd1;
        end
        ST_NEXT: begin
          if (more_passes) begin
            pass_d  = pass_q + 2'd1;
            state_d = ST_SETUP;
          end else begin
            done_d  = 1'b1;
            ran_d   = 1'b1;
            disp_d  = pass_q[0];
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_WAIT_LOCK;
      endcase
    end
  end

  always_ff @(posedge vga_ctrl_clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_WAIT_LOCK;
      passes_q <= 3'd0;
      copy_q   <= 1'b0;
      ops_q    <= 4'd0;
      pass_q   <= 2'd0;
      drain_q  <= 8'd0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      ran_q    <= 1'b0;
      disp_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      passes_q <= passes_d;
      copy_q   <= copy_d;
      ops_q    <= ops_d;
      pass_q   <= pass_d;
      drain_q  <= drain_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      ran_q    <= ran_d;
      disp_q   <= disp_d;
    end
  end

  // Write side mirrors the read stream PIPE_LAT cycles later; lock loss flushes it.
  always_ff @(posedge vga_ctrl_clk or posedge rst) begin
    if (rst) begin
      wv_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) wa_q[i] <= '0;
    end else begin
      wv_q[0] <= stream_v && pll_lock;
      wa_q[0] <= rd_cnt;
      for (int i = 1; i < PIPE_LAT; i++) begin
        wv_q[i] <= wv_q[i-1] && pll_lock;
        wa_q[i] <= wa_q[i-1];
      end
    end
  end

  assign filt_on     = (state_q inside {ST_SETUP, ST_STREAM, ST_DRAIN}) && !copy_q;
  assign erosion_en  = filt_on && (ops_q[pass_q] == OP_ERO);
  assign dilation_en = filt_on && (ops_q[pass_q] == OP_DIL);

  assign rd_addr   = rd_cnt;
  assign rd_src    = pass_src(pass_q);
  assign wr_addr   = wa_q[PIPE_LAT-1];
  assign wr_en     = wv_q[PIPE_LAT-1];
  assign wr_dst    = pass_q[0];
  assign busy      = state_q inside {ST_SETUP, ST_STREAM, ST_DRAIN, ST_NEXT};
  assign done      = done_q;
  assign abort     = abort_q;
  assign vga_flag  = ran_q && (state_q == ST_IDLE);
  assign disp_buf  = disp_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_morph_pass_sequencer.sv
// Bench for morph_pass_sequencer on an 8x4 frame: random pass/op runs against
// a queue of expected writes, plus lock-loss and mid-pass reset scenarios.
module tb_morph_pass_sequencer;

  localparam int IMG_W = 8;
  localparam int IMG_H = 4;
  localparam int ADDR_W = 8;
  localparam int PIPE_LAT = 3;
  localparam int N = IMG_W * IMG_H;
  localparam int EW = 13;

  logic              vga_ctrl_clk = 1'b0;
  logic              rst;
  logic              pll_lock;
  logic              start;
  logic [2:0]        num_passes;
  logic [3:0]        op_seq;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        rd_src;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic              wr_dst;
  logic              erosion_en;
  logic              dilation_en;
  logic              busy;
  logic              done;
  logic              abort;
  logic              vga_flag;
  logic              disp_buf;
  logic [2:0]        dbg_state;

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;
  int both_hi = 0;

  // Expected write entry: {filt_en[1:0] (ero,dil), rd_src[1:0], wr_dst, addr[7:0]}
  logic [EW-1:0] exp_q[$];
  logic [ADDR_W-1:0] ha [4];
  logic [1:0]        hs [4];

  morph_pass_sequencer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .vga_ctrl_clk (vga_ctrl_clk),
    .rst          (rst),
    .pll_lock     (pll_lock),
    .start        (start),
    .num_passes   (num_passes),
    .op_seq       (op_seq),
    .rd_addr      (rd_addr),
    .rd_src       (rd_src),
    .wr_addr      (wr_addr),
    .wr_en        (wr_en),
    .wr_dst       (wr_dst),
    .erosion_en   (erosion_en),
    .dilation_en  (dilation_en),
    .busy         (busy),
    .done         (done),
    .abort        (abort),
    .vga_flag     (vga_flag),
    .disp_buf     (disp_buf),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  always #5 vga_ctrl_clk = ~vga_ctrl_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a pass p writes every pixel once, in order, to buffer p%2,
  // fed from ROM (p=0) or the buffer of pass p-1, filtered by op_seq[p].
  task automatic push_pass(input int p, input bit copy, input logic [3:0] ops, input int nwr);
    logic [1:0] src, en;
    src = (p == 0) ? 2'd0 : ((p % 2 == 1) ? 2'd1 : 2'd2);
    en  = copy ? 2'b00 : (ops[p] ? 2'b01 : 2'b10);
    for (int a = 0; a < nwr; a++) exp_q.push_back({en, src, 1'(p % 2), 8'(a)});
  endtask

  function automatic int n_passes(input logic [2:0] num);
    if (num == 3'd0) return 1;
    if (num > 3'd4) return 4;
    return int'(num);
  endfunction

  // Scoreboard: advance one cycle and check any write against the model.
  task automatic tick();
    logic [EW-1:0] e;
    @(negedge vga_ctrl_clk);
    for (int i = 3; i > 0; i--) begin
      ha[i] = ha[i-1];
      hs[i] = hs[i-1];
    end
    ha[0] = rd_addr;
    hs[0] = rd_src;
    if (done) done_cnt++;
    if (erosion_en && dilation_en) both_hi++;
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        chk("wr_extra", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e[7:0]));
        chk("wr_dst", 32'(wr_dst), 32'(e[8]));
        chk("rd_addr_lat", 32'(ha[3]), 32'(e[7:0]));
        chk("rd_src_lat", 32'(hs[3]), 32'(e[10:9]));
        chk("filt_en", 32'({erosion_en, dilation_en}), 32'(e[12:11]));
      end
    end
  endtask

  task automatic run(input logic [2:0] num, input logic [3:0] ops, input bit mid_start);
    int np, d0, mx, ms;
    bit seen;
    np = n_passes(num);
    for (int p = 0; p < np; p++) push_pass(p, num == 3'd0, ops, N);
    d0 = done_cnt;
    mx = 0;
    seen = 0;
    ms = $urandom_range(3, 25);
    num_passes = num;
    op_seq = ops;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("abort_clr", 32'(abort), 32'd0);
    chk("busy_go", 32'(busy), 32'd1);
    for (int c = 0; c < 400 && !seen; c++) begin
      start = (mid_start && c == ms);
      tick();
      if (int'(rd_addr) > mx) mx = int'(rd_addr);
      if (done) seen = 1;
    end
    start = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    chk("disp_buf", 32'(disp_buf), 32'((np - 1) % 2));
    chk("vga_flag", 32'(vga_flag), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    repeat (6) tick();
    chk("done_once", 32'(done_cnt - d0), 32'd1);
    chk("no_requeue", 32'(busy), 32'd0);
    chk("exp_left", 32'(exp_q.size()), 32'd0);
    chk("rd_max", 32'(mx), 32'(N - 1));
    exp_q.delete();
  endtask

  initial begin
    int d0;
    bit found;
    logic [3:0] ops;
    for (int i = 0; i < 4; i++) begin
      ha[i] = '0;
      hs[i] = '0;
    end
    rst = 1'b1;
    pll_lock = 1'b0;
    start = 1'b0;
    num_passes = 3'd0;
    op_seq = 4'd0;
    tick();
    tick();
    chk("rst_outs", 32'({rd_addr, rd_src, wr_addr, wr_en, wr_dst, erosion_en, dilation_en,
                         busy, done, abort, vga_flag, disp_buf}), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    chk("wait_lock_state", 32'(dbg_state), 32'd0);
    chk("wait_lock_busy", 32'(busy), 32'd0);
    pll_lock = 1'b1;
    repeat (2) tick();
    chk("vga_before_run", 32'(vga_flag), 32'd0);

    // Directed runs, then randomized ones
    run(3'd1, 4'b0000, 1'b0);
    run(3'd2, 4'b0010, 1'b1);
    run(3'd7, 4'b1111, 1'b1);
    run(3'd0, 4'($urandom_range(0, 15)), 1'b1);
    repeat (6) run(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

    // Lock loss at rd_addr 10 of pass 1: writes for pixels 0..7 of pass 1 retire
    ops = 4'($urandom_range(0, 15));
    push_pass(0, 1'b0, ops, N);
    push_pass(1, 1'b0, ops, 8);
    d0 = done_cnt;
    num_passes = 3'd2;
    op_seq = ops;
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      tick();
      if (busy && rd_src == 2'b01 && rd_addr == 8'd10) found = 1;
    end
    chk("lock_point_found", 32'(found), 32'd1);
    pll_lock = 1'b0;
    tick();
    chk("lock_wr_en", 32'(wr_en), 32'd0);
    chk("lock_abort", 32'(abort), 32'd1);
    chk("lock_busy", 32'(busy), 32'd0);
    chk("lock_filt", 32'({erosion_en, dilation_en}), 32'd0);
    repeat (4) tick();
    chk("lock_exp_left", 32'(exp_q.size()), 32'd0);
    chk("lock_no_done", 32'(done_cnt - d0), 32'd0);
    exp_q.delete();
    pll_lock = 1'b1;
    repeat (3) tick();
    chk("abort_sticky", 32'(abort), 32'd1);
    run(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'b0);

    // Mid-pass reset at rd_addr 20 of pass 0, with an ignored start in between
    ops = 4'($urandom_range(0, 15));
    push_pass(0, 1'b0, ops, 18);
    d0 = done_cnt;
    num_passes = 3'd2;
    op_seq = ops;
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      start = (c == 8);
      tick();
      if (busy && rd_src == 2'b00 && rd_addr == 8'd20) found = 1;
    end
    start = 1'b0;
    chk("rst_point_found", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_outs", 32'({rd_addr, rd_src, wr_addr, wr_en, wr_dst, erosion_en, dilation_en,
                            busy, done, abort, vga_flag, disp_buf}), 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (50) tick();
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("midrst_exp_left", 32'(exp_q.size()), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_vga", 32'(vga_flag), 32'd0);
    exp_q.delete();
    run(3'd3, 4'($urandom_range(0, 15)), 1'b1);

    chk("filt_exclusive", 32'(both_hi), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
